// File: rtl/axi_4kb_burst_splitter.sv
// AXI4 AW/AR address-channel splitter: re-issues each accepted burst as one or
// more sub-bursts that never cross a 2^BOUNDARY_BITS-byte boundary.
module axi_4kb_burst_splitter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int ID_WIDTH      = 5,
  parameter int BOUNDARY_BITS = 12
) (
  input  logic                  ACLK_i,
  input  logic                  ARESETn_i,
  input  logic [ID_WIDTH-1:0]   s_ID_i,
  input  logic [ADDR_WIDTH-1:0] s_ADDR_i,
  input  logic [LEN_WIDTH-1:0]  s_LEN_i,
  input  logic [SIZE_WIDTH-1:0] s_SIZE_i,
  input  logic [1:0]            s_BURST_i,
  input  logic                  s_VALID_i,
  output logic                  s_READY_o,
  output logic [ID_WIDTH-1:0]   m_ID_o,
  output logic [ADDR_WIDTH-1:0] m_ADDR_o,
  output logic [LEN_WIDTH-1:0]  m_LEN_o,
  output logic [SIZE_WIDTH-1:0] m_SIZE_o,
  output logic [1:0]            m_BURST_o,
  output logic                  m_SPLIT_o,
  output logic                  m_LAST_o,
  output logic                  m_VALID_o,
  input  logic                  m_READY_i
);

  localparam int CNT_WIDTH = ((LEN_WIDTH > BOUNDARY_BITS) ? LEN_WIDTH : BOUNDARY_BITS) + 2;
  localparam int HI_WIDTH  = ADDR_WIDTH - BOUNDARY_BITS;
  localparam logic [CNT_WIDTH-1:0] BOUND_BYTES = CNT_WIDTH'(1) << BOUNDARY_BITS;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [CNT_WIDTH-1:0]   rem_q, rem_d;
  logic                   split_q, split_d;

  logic                   issue;
  logic [CNT_WIDTH-1:0]   avail_cur;
  logic [CNT_WIDTH-1:0]   piece_beats;
  logic                   cut;
  logic [CNT_WIDTH-1:0]   req_beats;

  // Beats of the given size that fit between the (size-aligned) offset and the next boundary.
  function automatic logic [CNT_WIDTH-1:0] beats_to_boundary(
    input logic [BOUNDARY_BITS-1:0] offset,
    input logic [SIZE_WIDTH-1:0]    size
  );
    logic [CNT_WIDTH-1:0] mask;
    logic [CNT_WIDTH-1:0] aligned;
    mask    = {CNT_WIDTH{1'b1}} << size;
    aligned = CNT_WIDTH'(offset) & mask;
    return (BOUND_BYTES - aligned) >> size;
  endfunction

  assign issue       = (state_q == ISSUE);
  assign avail_cur   = beats_to_boundary(addr_q[BOUNDARY_BITS-1:0], size_q);
  assign cut         = (burst_q == BURST_INCR) && (rem_q > avail_cur);
  assign piece_beats = cut ? avail_cur : rem_q;
  assign req_beats   = CNT_WIDTH'(s_LEN_i) + CNT_WIDTH'(1);

  // Master side is driven purely from the working registers; zeroed while idle.
  assign s_READY_o = ~issue;
  assign m_VALID_o = issue;
  assign m_ID_o    = issue ? id_q    : '0;
  assign m_ADDR_o  = issue ? addr_q  : '0;
  assign m_SIZE_o  = issue ? size_q  : '0;
  assign m_BURST_o = issue ? burst_q : '0;
  assign m_LEN_o   = issue ? LEN_WIDTH'(piece_beats - CNT_WIDTH'(1)) : '0;
  assign m_LAST_o  = issue & ~cut;
  assign m_SPLIT_o = issue & split_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    rem_d   = rem_q;
    split_d = split_q;
    case (state_q)
      IDLE: begin
        if (s_VALID_i) begin
          id_d    = s_ID_i;
          addr_d  = s_ADDR_i;
          size_d  = s_SIZE_i;
          burst_d = s_BURST_i;
          rem_d   = req_beats;
          split_d = (s_BURST_i == BURST_INCR) &&
                    (req_beats > beats_to_boundary(s_ADDR_i[BOUNDARY_BITS-1:0], s_SIZE_i));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_READY_i) begin
          if (!cut) begin
            state_d = IDLE;
          end else begin
            // Later pieces start on the next boundary; wraps modulo 2^ADDR_WIDTH.
            addr_d = {addr_q[ADDR_WIDTH-1:BOUNDARY_BITS] + HI_WIDTH'(1), {BOUNDARY_BITS{1'b0}}};
            rem_d  = rem_q - avail_cur;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rem_q   <= '0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      rem_q   <= rem_d;
      split_q <= split_d;
    end
  end

endmodule

// File: tb/tb_axi_4kb_burst_splitter.sv
// Bench for axi_4kb_burst_splitter: directed scenarios plus random requests
// checked against a beat-by-beat page-grouping reference model.
module tb_axi_4kb_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  s_ID_i;
  logic [31:0] s_ADDR_i;
  logic [7:0]  s_LEN_i;
  logic [2:0]  s_SIZE_i;
  logic [1:0]  s_BURST_i;
  logic        s_VALID_i;
  logic        s_READY_o;
  logic [4:0]  m_ID_o;
  logic [31:0] m_ADDR_o;
  logic [7:0]  m_LEN_o;
  logic [2:0]  m_SIZE_o;
  logic [1:0]  m_BURST_o;
  logic        m_SPLIT_o;
  logic        m_LAST_o;
  logic        m_VALID_o;
  logic        m_READY_i;

  axi_4kb_burst_splitter dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .s_ID_i(s_ID_i), .s_ADDR_i(s_ADDR_i), .s_LEN_i(s_LEN_i), .s_SIZE_i(s_SIZE_i),
    .s_BURST_i(s_BURST_i), .s_VALID_i(s_VALID_i), .s_READY_o(s_READY_o),
    .m_ID_o(m_ID_o), .m_ADDR_o(m_ADDR_o), .m_LEN_o(m_LEN_o), .m_SIZE_o(m_SIZE_o),
    .m_BURST_o(m_BURST_o), .m_SPLIT_o(m_SPLIT_o), .m_LAST_o(m_LAST_o),
    .m_VALID_o(m_VALID_o), .m_READY_i(m_READY_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    bit          last;
  } piece_t;

  piece_t      exp_q[$];
  bit          exp_split;
  logic [4:0]  exp_id;
  logic [2:0]  exp_size;
  logic [1:0]  exp_burst;

  // Reference: walk every beat address, cut a new piece whenever the 4 KB page changes.
  function automatic void build_model(input logic [4:0] id, input logic [31:0] addr,
                                      input int len, input int size, input logic [1:0] burst);
    logic [31:0] base, ba, start;
    logic [19:0] cur_pg;
    int          cnt;
    int          nbytes;
    exp_q.delete();
    exp_id = id; exp_size = size[2:0]; exp_burst = burst;
    if (burst != 2'b01) begin
      exp_q.push_back('{addr, len, 1'b1});
      exp_split = 1'b0;
      return;
    end
    nbytes = 1 << size;
    base   = addr & ~(32'(nbytes) - 32'd1);
    start  = addr;
    cur_pg = addr[31:12];
    cnt    = 0;
    for (int k = 0; k <= len; k++) begin
      ba = base + 32'(k * nbytes);
      if (ba[31:12] != cur_pg) begin
        exp_q.push_back('{start, cnt - 1, 1'b0});
        start  = ba;
        cur_pg = ba[31:12];
        cnt    = 0;
      end
      cnt++;
    end
    exp_q.push_back('{start, cnt - 1, 1'b1});
    exp_split = (exp_q.size() > 1);
  endfunction

  task automatic accept(input logic [4:0] id, input logic [31:0] addr, input int len,
                        input int size, input logic [1:0] burst);
    build_model(id, addr, len, size, burst);
    @(negedge clk);
    chk("s_ready_before_accept", s_READY_o, 1);
    chk("m_valid_before_accept", m_VALID_o, 0);
    s_ID_i = id; s_ADDR_i = addr; s_LEN_i = len[7:0]; s_SIZE_i = size[2:0];
    s_BURST_i = burst; s_VALID_i = 1'b1; m_READY_i = 1'b0;
    @(posedge clk);
    #1;
    // Scramble request inputs: the pieces must come from latched state only.
    s_VALID_i = 1'b0;
    s_ID_i = 5'($urandom); s_ADDR_i = $urandom; s_LEN_i = 8'($urandom);
    s_SIZE_i = 3'($urandom); s_BURST_i = 2'($urandom);
  endtask

  task automatic check_piece(input int idx);
    chk($sformatf("m_valid_p%0d", idx), m_VALID_o, 1);
    chk($sformatf("s_ready_p%0d", idx), s_READY_o, 0);
    chk($sformatf("m_addr_p%0d", idx),  m_ADDR_o, exp_q[idx].addr);
    chk($sformatf("m_len_p%0d", idx),   m_LEN_o, 64'(exp_q[idx].len));
    chk($sformatf("m_last_p%0d", idx),  m_LAST_o, exp_q[idx].last);
    chk($sformatf("m_split_p%0d", idx), m_SPLIT_o, exp_split);
    chk($sformatf("m_id_p%0d", idx),    m_ID_o, exp_id);
    chk($sformatf("m_size_p%0d", idx),  m_SIZE_o, exp_size);
    chk($sformatf("m_burst_p%0d", idx), m_BURST_o, exp_burst);
  endtask

  task automatic drain(input bit rnd_ready);
    int guard;
    for (int i = 0; i < exp_q.size(); i++) begin
      guard = 0;
      forever begin
        @(negedge clk);
        m_READY_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (guard >= 20) m_READY_i = 1'b1;
        check_piece(i);
        @(posedge clk);
        #1;
        if (m_READY_i) break;
        guard++;
      end
    end
    m_READY_i = 1'b0;
    @(negedge clk);
    chk("m_valid_after_last", m_VALID_o, 0);
    chk("s_ready_after_last", s_READY_o, 1);
  endtask

  task automatic run_req(input logic [4:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst, input bit rnd_ready);
    accept(id, addr, len, size, burst);
    drain(rnd_ready);
  endtask

  initial begin
    rst_n = 1'b0;
    s_ID_i = '0; s_ADDR_i = '0; s_LEN_i = '0; s_SIZE_i = '0; s_BURST_i = '0;
    s_VALID_i = 1'b0; m_READY_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_VALID_o, 0);
    chk("rst_s_ready", s_READY_o, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_m_split", m_SPLIT_o, 0);
    chk("post_rst_m_last",  m_LAST_o, 0);
    chk("post_rst_m_id",    m_ID_o, 0);
    chk("post_rst_m_addr",  m_ADDR_o, 0);
    chk("post_rst_m_len",   m_LEN_o, 0);

    // Directed scenarios
    run_req(5'd1, 32'h0000_0018, 30, 2, 2'b01, 1'b0);
    run_req(5'd2, 32'h0000_1FFE, 7,  0, 2'b01, 1'b0);
    run_req(5'd3, 32'h0000_0FF3, 3,  2, 2'b01, 1'b1);
    run_req(5'd4, 32'h0000_0FF5, 4,  2, 2'b01, 1'b1);
    run_req(5'd5, 32'h0000_0F80, 64, 7, 2'b01, 1'b1);
    run_req(5'd6, 32'h0000_0FFC, 7,  2, 2'b00, 1'b0);
    run_req(5'd7, 32'h0000_0FFC, 7,  2, 2'b10, 1'b0);
    run_req(5'd8, 32'h0000_0FFC, 7,  2, 2'b11, 1'b0);
    run_req(5'd9, 32'hFFFF_FFF0, 7,  2, 2'b01, 1'b1);

    // Backpressure on piece 2, then reset while it is still pending
    accept(5'd10, 32'h0000_1FFE, 7, 0, 2'b01);
    @(negedge clk);
    m_READY_i = 1'b1;
    check_piece(0);
    @(posedge clk);
    #1 m_READY_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_piece(1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_VALID_o, 0);
    chk("midrst_s_ready", s_READY_o, 1);
    chk("midrst_m_last",  m_LAST_o, 0);
    chk("midrst_m_split", m_SPLIT_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_READY_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_m_valid", m_VALID_o, 0);
      chk("after_rst_s_ready", s_READY_o, 1);
    end
    m_READY_i = 1'b0;
    run_req(5'd11, 32'h0000_0018, 30, 2, 2'b01, 1'b0);

    // Random requests biased toward the top of a page
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[11:8] = 4'hF;
      run_req(5'($urandom), a, $urandom_range(0, 255), $urandom_range(0, 7),
              2'($urandom_range(0, 5) == 0 ? $urandom : 1), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_4kb_burst_splitter.md
# axi_4kb_burst_splitter

Registered AXI4 address-channel splitter that sits between a master's AW/AR channel and the interconnect crossbar. It accepts one burst request via VALID/READY and re-issues it as one or more sub-bursts, none of which crosses a 2^BOUNDARY_BITS-byte boundary. It also handles requests that cross several boundaries. Each sub-burst is tagged so downstream response logic can merge the pieces back into the original transaction.

## Interface

Parameters:
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, AxLEN width (beats = LEN+1)
- SIZE_WIDTH, 3, AxSIZE width
- ID_WIDTH, 5, AxID width, passed through unchanged
- BOUNDARY_BITS, 12, log2 of boundary in bytes; must satisfy BOUNDARY_BITS ≥ 2^SIZE_WIDTH−1

Ports:
- ACLK_i  in  1  clock, all state on rising edge
- ARESETn_i  in  1  asynchronous active-low reset
- s_ID_i  in  ID_WIDTH  request ID
- s_ADDR_i  in  ADDR_WIDTH  request start address, may be unaligned
- s_LEN_i  in  LEN_WIDTH  request length−1
- s_SIZE_i  in  SIZE_WIDTH  bytes/beat = 2^SIZE
- s_BURST_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_VALID_i  in  1  request valid
- s_READY_o  out  1  request accepted when high with s_VALID_i
- m_ID_o  out  ID_WIDTH  sub-burst ID (= latched s_ID_i)
- m_ADDR_o  out  ADDR_WIDTH  sub-burst address
- m_LEN_o  out  LEN_WIDTH  sub-burst length−1
- m_SIZE_o  out  SIZE_WIDTH  = latched s_SIZE_i
- m_BURST_o  out  2  = latched s_BURST_i
- m_SPLIT_o  out  1  original request was split into ≥2 pieces
- m_LAST_o  out  1  this is the final piece of the original request
- m_VALID_o  out  1  sub-burst valid
- m_READY_i  in  1  sub-burst accepted

## Operation

- FSM states are IDLE and ISSUE.
- IDLE:
  - s_READY_o=1, m_VALID_o=0.
  - On s_VALID_i&s_READY_o, latch ID/ADDR/SIZE/BURST into working regs, set rem_beats=LEN+1, then go to ISSUE.
- ISSUE:
  - s_READY_o=0, m_VALID_o=1.
  - Outputs are a combinational function of working regs only, never of s_* inputs.
- Piece computation uses CNT_WIDTH = max(LEN_WIDTH, BOUNDARY_BITS)+2 for all counts:
  - aligned = cur_addr with low SIZE bits cleared
  - avail = (2^BOUNDARY_BITS − aligned[BOUNDARY_BITS-1:0]) >> SIZE
  - INCR and rem_beats > avail: emit m_LEN_o=avail−1, m_LAST_o=0.
  - Otherwise: emit m_LEN_o=rem_beats−1, m_LAST_o=1.
  - m_ADDR_o=cur_addr. The first piece keeps the unaligned address; later pieces are boundary-aligned.
- On m_VALID_o&m_READY_i in ISSUE:
  - If m_LAST_o=1: return to IDLE.
  - Else: cur_addr = (cur_addr[ADDR_WIDTH-1:BOUNDARY_BITS]+1) << BOUNDARY_BITS; rem_beats −= avail; stay in ISSUE.
- m_SPLIT_o: latched at acceptance as (INCR and LEN+1 > avail of the first piece). It is constant for all pieces of one request.
- FIXED and WRAP bursts are never split: one piece, outputs equal the inputs, m_SPLIT_o=0, m_LAST_o=1. Burst code 11 is treated as FIXED.
- Address increment wraps modulo 2^ADDR_WIDTH; no error is flagged.

## Timing

- Reset (async assert, sync release): state=IDLE, m_VALID_o=0, s_READY_o=1, m_SPLIT_o=0, m_LAST_o=0. m_ID_o, m_ADDR_o and m_LEN_o are 0.
- Latency: m_VALID_o rises on the cycle after s_* acceptance.
- Throughput:
  - N-piece request occupies N+1 cycles minimum: 1 IDLE accept cycle plus N issue cycles.
  - Back-to-back unsplit requests give 1 request per 2 cycles.
- Backpressure: while m_VALID_o=1 and m_READY_i=0, all m_* outputs hold stable and s_READY_o stays 0.
- m_VALID_o never deasserts without a handshake, except on reset.
- s_READY_o does not depend combinationally on m_READY_i.
- Reset mid-ISSUE: the in-flight request is discarded and m_VALID_o drops immediately. No partial piece is reissued after release.

## Test plan

Defaults apply: BOUNDARY_BITS=12, INCR unless noted.

1. No cross: ADDR=0x18, LEN=30, SIZE=2 -> one piece 1 cycle after accept: ADDR=0x18, LEN=30, LAST=1, SPLIT=0.
2. Single cross: ADDR=0x1FFE, LEN=7, SIZE=0 -> piece 1 {0x1FFE, LEN=1, LAST=0}, piece 2 {0x2000, LEN=5, LAST=1}; SPLIT=1 on both.
3. Unaligned edge cases, both SIZE=2:
   - ADDR=0x0FF3, LEN=3 -> exact fit, one piece {0x0FF3, LEN=3, SPLIT=0}.
   - ADDR=0x0FF5, LEN=4 -> {0x0FF5, LEN=2}, then {0x1000, LEN=1, LAST=1}.
4. Multi-cross: ADDR=0x0F80, SIZE=7, LEN=64 -> {0x0F80, LEN=0}, then {0x1000, LEN=31}, then {0x2000, LEN=31, LAST=1}. s_READY_o stays low until after the third handshake.
5. Non-INCR: BURST=00 and BURST=10, each with ADDR=0x0FFC, LEN=7, SIZE=2 -> single unchanged piece, SPLIT=0, LAST=1.
6. Backpressure and reset:
   - Hold m_READY_i=0 for 3 cycles on piece 2 of scenario 2 -> outputs stable.
   - Then assert ARESETn_i=0 mid-ISSUE -> m_VALID_o=0 and s_READY_o=1 after release; a new request is accepted cleanly.
